// File: rtl/cpu_write_diff_pio_pkg.sv
// Shared definitions for the cpu_write_diff_pio slice.
// Contents:
//   - register word addresses of the Avalon-MM slave
//   - strobe FSM state type (IDLE / PULSE / GAP)
//   - STROBE_LEN register width
package cpu_write_diff_pio_pkg;

    localparam int STROBE_LEN_W = 8;

    localparam logic [2:0] ADDR_DATA       = 3'd0;
    localparam logic [2:0] ADDR_STROBE_LEN = 3'd1;
    localparam logic [2:0] ADDR_STATUS     = 3'd2;
    localparam logic [2:0] ADDR_TRIGGER    = 3'd3;
    localparam logic [2:0] ADDR_OUTSET     = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR   = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } strobe_state_t;

endpackage

// File: rtl/cpu_write_diff_pio_strobe.sv
// One-shot strobe generator.
// A trigger in IDLE starts a pulse of max(len,1) cycles, followed by a single
// GAP cycle before the block can be triggered again.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   trigger       - one-cycle request (TRIGGER register write)
//   len           - pulse length sampled only when a pulse starts
//   strobe        - high exactly while in PULSE
//   busy          - high in PULSE and GAP
//   overrun_set   - trigger arrived while busy (trigger itself is dropped)
module cpu_write_diff_pio_strobe
    import cpu_write_diff_pio_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    trigger,
    input  logic [STROBE_LEN_W-1:0] len,
    output logic                    strobe,
    output logic                    busy,
    output logic                    overrun_set
);

    strobe_state_t           state_q, state_d;
    logic [STROBE_LEN_W-1:0] count_q, count_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        overrun_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_d = ST_PULSE;
                    // len is latched here, so later STROBE_LEN writes
                    // cannot stretch or cut the running pulse. len=0 acts as 1.
                    count_d = (len == '0) ? '0 : len - 8'd1;
                end
            end
            ST_PULSE: begin
                overrun_set = trigger;
                if (count_q == '0) begin
                    state_d = ST_GAP;
                end else begin
                    count_d = count_q - 8'd1;
                end
            end
            ST_GAP: begin
                overrun_set = trigger;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    // Decoded straight from the state flop so an asynchronous reset drops
    // the strobe without waiting for a clock edge.
    always_comb begin
        strobe = (state_q == ST_PULSE);
        busy   = (state_q != ST_IDLE);
    end

endmodule

// File: rtl/cpu_write_diff_pio.sv
// Avalon-MM parallel output port with a programmable one-shot strobe.
// Register map (word addresses):
//   0 DATA (R/W), 1 STROBE_LEN (R/W, 8 bits), 2 STATUS (bit0 busy,
//   bit1 sticky overrun, any write clears overrun), 3 TRIGGER (WO),
//   4 OUTSET (WO), 5 OUTCLEAR (WO), 6-7 reserved (read 0).
// Ports:
//   clk, reset_n          - clock, asynchronous active-low reset
//   chipselect, write_n   - a write happens when chipselect=1 and write_n=0
//   address, writedata    - word select and write data
//   readdata              - registered every cycle from the address mux
//   out_port              - WIDTH output pins
//   out_strobe            - one-shot pulse
module cpu_write_diff_pio
    import cpu_write_diff_pio_pkg::*;
#(
    parameter int WIDTH            = 8,
    parameter int RESET_VALUE      = 0,
    parameter int STROBE_LEN_RESET = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             chipselect,
    input  logic [2:0]       address,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             out_strobe
);

    logic [WIDTH-1:0]        out_port_q, out_port_d;
    logic [STROBE_LEN_W-1:0] strobe_len_q, strobe_len_d;
    logic                    overrun_q, overrun_d;
    logic [31:0]             readdata_q, readdata_d;

    logic wr_en;
    logic trigger;
    logic busy;
    logic overrun_set;

    always_comb begin
        wr_en   = chipselect && !write_n;
        trigger = wr_en && (address == ADDR_TRIGGER);
    end

    cpu_write_diff_pio_strobe u_strobe (
        .clk         (clk),
        .reset_n     (reset_n),
        .trigger     (trigger),
        .len         (strobe_len_q),
        .strobe      (out_strobe),
        .busy        (busy),
        .overrun_set (overrun_set)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port_q   <= WIDTH'(RESET_VALUE);
            strobe_len_q <= STROBE_LEN_W'(STROBE_LEN_RESET);
            overrun_q    <= 1'b0;
            readdata_q   <= '0;
        end else begin
            out_port_q   <= out_port_d;
            strobe_len_q <= strobe_len_d;
            overrun_q    <= overrun_d;
            readdata_q   <= readdata_d;
        end
    end

    // Register writes. Output-pin writes are independent of the strobe FSM.
    always_comb begin
        out_port_d   = out_port_q;
        strobe_len_d = strobe_len_q;
        overrun_d    = overrun_q;
        if (wr_en) begin
            case (address)
                ADDR_DATA:       out_port_d   = writedata[WIDTH-1:0];
                ADDR_STROBE_LEN: strobe_len_d = writedata[STROBE_LEN_W-1:0];
                ADDR_OUTSET:     out_port_d   = out_port_q | writedata[WIDTH-1:0];
                ADDR_OUTCLEAR:   out_port_d   = out_port_q & ~writedata[WIDTH-1:0];
                default:         ;
            endcase
        end
        // STATUS writes and a dropped trigger never coincide (different
        // addresses), so the order of these two is not a priority decision.
        if (wr_en && (address == ADDR_STATUS)) begin
            overrun_d = 1'b0;
        end else if (overrun_set) begin
            overrun_d = 1'b1;
        end
    end

    // Read mux is sampled every cycle, independent of chipselect.
    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA:       readdata_d = 32'(out_port_q);
            ADDR_STROBE_LEN: readdata_d = 32'(strobe_len_q);
            ADDR_STATUS:     readdata_d = {30'd0, overrun_q, busy};
            default:         readdata_d = '0;
        endcase
    end

    // Upper writedata bits are only meaningful for wide out_port builds.
    logic unused_writedata;
    assign unused_writedata = ^writedata;

    assign readdata = readdata_q;
    assign out_port = out_port_q;

endmodule

// File: tb/tb_cpu_write_diff_pio.sv
`timescale 1ns/1ps
module tb_cpu_write_diff_pio;

  localparam int W = 8;

  logic          clk;
  logic          reset_n;
  logic          chipselect;
  logic [2:0]    address;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [W-1:0]  out_port;
  logic          out_strobe;

  int n_checks;
  int n_fail;

  // reference model: registers plus the current pulse as an interval of edges
  logic [W-1:0]  m_out;
  logic [7:0]    m_len;
  logic          m_ovr;
  logic [31:0]   m_rd;
  int            cyc;
  int            t_start;
  int            t_w;

  cpu_write_diff_pio #(.WIDTH(W), .RESET_VALUE(0), .STROBE_LEN_RESET(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .address    (address),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .out_strobe (out_strobe)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // strobe high after edges [t_start, t_start+t_w-1]; busy one edge longer (GAP)
  function automatic bit strobe_at(int k);
    return (k >= t_start) && (k < t_start + t_w);
  endfunction

  function automatic bit busy_at(int k);
    return (k >= t_start) && (k <= t_start + t_w);
  endfunction

  task automatic model_reset();
    m_out   = '0;
    m_len   = 8'd4;
    m_ovr   = 1'b0;
    m_rd    = '0;
    t_start = -1000;
    t_w     = 0;
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock edge with the current inputs and update the model.
  task automatic cycle();
    logic [31:0] rd;
    @(posedge clk);
    cyc++;
    case (address)
      3'd0:    rd = 32'(m_out);
      3'd1:    rd = 32'(m_len);
      3'd2:    rd = {30'd0, m_ovr, busy_at(cyc - 1)};
      default: rd = '0;
    endcase
    if (chipselect && !write_n) begin
      case (address)
        3'd0: m_out = writedata[W-1:0];
        3'd1: m_len = writedata[7:0];
        3'd2: m_ovr = 1'b0;
        3'd3: begin
          if (busy_at(cyc - 1)) m_ovr = 1'b1;
          else begin
            t_start = cyc;
            t_w     = (m_len == 8'd0) ? 1 : int'(m_len);
          end
        end
        3'd4: m_out = m_out | writedata[W-1:0];
        3'd5: m_out = m_out & ~writedata[W-1:0];
        default: ;
      endcase
    end
    m_rd = rd;
    #1;
  endtask

  task automatic drive(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] d);
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = d;
    cycle();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    drive(1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [2:0] a);
    drive(1'b0, 1'b1, a, $urandom);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = '0;
    reset_n = 1'b0;
    model_reset();
    #2;
    n_checks++;
    if (out_port !== 8'h00 || out_strobe !== 1'b0 || readdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: out_port=%h strobe=%b readdata=%h, required 00/0/00000000", out_port, out_strobe, readdata);
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int a = 0; a < 3; a++) begin
      rd(3'(a));
      n_checks++;
      if (readdata !== m_rd) begin
        n_fail++;
        $display("FAIL reset_read_addr%0d: readdata=%h required %h", a, readdata, m_rd);
      end
    end
    n_checks++;
    if (out_port !== 8'h00 || out_strobe !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: out_port=%h strobe=%b, required 00/0", out_port, out_strobe);
    end
  endtask

  task automatic test_pio();
    logic [7:0] req [3];
    req[0] = 8'hA5; req[1] = 8'hAF; req[2] = 8'h2E;
    wr(3'd0, 32'hFFFF_FFA5);
    n_checks++;
    if (out_port !== req[0]) begin n_fail++; $display("FAIL pio_data: out_port=%h required %h", out_port, req[0]); end
    wr(3'd4, 32'h0000_000A);
    n_checks++;
    if (out_port !== req[1]) begin n_fail++; $display("FAIL pio_outset: out_port=%h required %h", out_port, req[1]); end
    wr(3'd5, 32'h0000_0081);
    n_checks++;
    if (out_port !== req[2]) begin n_fail++; $display("FAIL pio_outclear: out_port=%h required %h", out_port, req[2]); end
    rd(3'd0);
    rd(3'd0);
    n_checks++;
    if (readdata !== 32'h0000_002E) begin n_fail++; $display("FAIL pio_readback: readdata=%h required 0000002e", readdata); end
  endtask

  task automatic test_no_write();
    drive(1'b0, 1'b0, 3'd0, 32'h0000_0055);
    n_checks++;
    if (out_port !== m_out || out_port !== 8'h2E) begin n_fail++; $display("FAIL nowrite_cs0: out_port=%h required 2e", out_port); end
    drive(1'b1, 1'b1, 3'd0, 32'h0000_0055);
    n_checks++;
    if (out_port !== 8'h2E) begin n_fail++; $display("FAIL nowrite_wn1: out_port=%h required 2e", out_port); end
  endtask

  task automatic test_strobe(input logic [7:0] len);
    int s_cnt;
    int b_cnt;
    int exp_w;
    exp_w = (len == 8'd0) ? 1 : int'(len);
    s_cnt = 0;
    b_cnt = 0;
    wr(3'd1, {24'hABCDEF, len});
    wr(3'd3, $urandom);
    for (int i = 0; i < 14; i++) begin
      s_cnt += int'(out_strobe);
      b_cnt += int'(readdata[0]);
      n_checks++;
      if (out_strobe !== strobe_at(cyc) || readdata !== m_rd) begin
        n_fail++;
        $display("FAIL strobe_len%0d_cyc%0d: strobe=%b readdata=%h required %b/%h", len, i, out_strobe, readdata, strobe_at(cyc), m_rd);
      end
      rd(3'd2);
    end
    n_checks++;
    if (s_cnt !== exp_w) begin n_fail++; $display("FAIL strobe_width_len%0d: got %0d cycles required %0d", len, s_cnt, exp_w); end
    n_checks++;
    if (b_cnt !== exp_w + 1) begin n_fail++; $display("FAIL busy_width_len%0d: got %0d cycles required %0d", len, b_cnt, exp_w + 1); end
  endtask

  task automatic test_overrun();
    int s_cnt;
    wr(3'd1, 32'd5);
    wr(3'd3, 32'd0);
    s_cnt = int'(out_strobe);
    rd(3'd2);
    s_cnt += int'(out_strobe);
    wr(3'd3, 32'd0);
    s_cnt += int'(out_strobe);
    rd(3'd2);
    n_checks++;
    if (readdata !== 32'h3) begin n_fail++; $display("FAIL overrun_status: readdata=%h required 00000003", readdata); end
    for (int i = 0; i < 10; i++) begin
      s_cnt += int'(out_strobe);
      n_checks++;
      if (out_strobe !== strobe_at(cyc) || readdata !== m_rd) begin
        n_fail++;
        $display("FAIL overrun_cyc%0d: strobe=%b readdata=%h required %b/%h", i, out_strobe, readdata, strobe_at(cyc), m_rd);
      end
      rd(3'd2);
    end
    n_checks++;
    if (s_cnt !== 5) begin n_fail++; $display("FAIL overrun_width: got %0d cycles required 5", s_cnt); end
    n_checks++;
    if (readdata !== 32'h2) begin n_fail++; $display("FAIL overrun_sticky: readdata=%h required 00000002", readdata); end
    wr(3'd2, $urandom);
    rd(3'd2);
    n_checks++;
    if (readdata !== 32'h0) begin n_fail++; $display("FAIL overrun_clear: readdata=%h required 00000000", readdata); end
  endtask

  task automatic test_reset_mid_pulse();
    int s_cnt;
    wr(3'd1, 32'd8);
    wr(3'd3, 32'd0);
    wr(3'd3, 32'd0);
    rd(3'd2);
    reset_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (out_strobe !== 1'b0 || out_port !== 8'h00 || readdata !== 32'h0) begin
      n_fail++;
      $display("FAIL midreset_async: strobe=%b out_port=%h readdata=%h required 0/00/00000000", out_strobe, out_port, readdata);
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    // first edge after release carries the trigger
    wr(3'd3, 32'd0);
    s_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      s_cnt += int'(out_strobe);
      n_checks++;
      if (out_strobe !== strobe_at(cyc) || readdata !== m_rd) begin
        n_fail++;
        $display("FAIL midreset_cyc%0d: strobe=%b readdata=%h required %b/%h", i, out_strobe, readdata, strobe_at(cyc), m_rd);
      end
      rd(3'd2);
    end
    n_checks++;
    if (s_cnt !== 4) begin n_fail++; $display("FAIL midreset_width: got %0d cycles required 4", s_cnt); end
  endtask

  task automatic test_random();
    logic [2:0]  a;
    logic [31:0] d;
    for (int i = 0; i < 300; i++) begin
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      if (a == 3'd1) d = (d & 32'hFFFF_FF00) | 32'($urandom_range(0, 6));
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d);
      n_checks++;
      if (out_port !== m_out || out_strobe !== strobe_at(cyc) || readdata !== m_rd) begin
        n_fail++;
        $display("FAIL random_%0d: out_port=%h strobe=%b readdata=%h required %h/%b/%h",
                 i, out_port, out_strobe, readdata, m_out, strobe_at(cyc), m_rd);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    test_reset();
    test_pio();
    test_no_write();
    test_strobe(8'd3);
    test_strobe(8'd0);
    test_overrun();
    test_reset_mid_pulse();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cpu_write_diff_pio.md
CPU_WRITE_DIFF_PIO -- requirements
Module: cpu_write_diff_pio

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the out_port width (1..32).
REQ-002 The block SHALL have parameter RESET_VALUE, default 0, giving the out_port value after reset.
REQ-003 The block SHALL have parameter STROBE_LEN_RESET, default 4, giving the STROBE_LEN value after reset.
REQ-004 The block SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port chipselect, input, 1 bit: Avalon-MM slave select.
REQ-007 The block SHALL have port address, input, 3 bits: word register select.
REQ-008 The block SHALL have port write_n, input, 1 bit: active-low write strobe, qualified by chipselect.
REQ-009 The block SHALL have port writedata, input, 32 bits: write data.
REQ-010 The block SHALL have port readdata, output, 32 bits: registered read data.
REQ-011 The block SHALL have port out_port, output, WIDTH bits: registered output pins.
REQ-012 The block SHALL have port out_strobe, output, 1 bit: one-shot strobe pulse.

Function
REQ-013 A write SHALL occur only when chipselect=1 and write_n=0 on a rising clk edge; all other cycles leave registers unchanged.
REQ-014 The register map SHALL be as follows.
- 0 DATA: R/W.
- 1 STROBE_LEN: R/W, bits[7:0].
- 2 STATUS: bit0 busy, bit1 overrun.
- 3 TRIGGER: write-only.
- 4 OUTSET: write-only.
- 5 OUTCLEAR: write-only.
- 6, 7: reserved.
REQ-015 A DATA write SHALL load out_port <= writedata[WIDTH-1:0], visible on out_port the cycle after the write edge.
REQ-016 An OUTSET write SHALL set out_port <= out_port | writedata[WIDTH-1:0].
REQ-017 An OUTCLEAR write SHALL set out_port <= out_port & ~writedata[WIDTH-1:0].
REQ-018 A STROBE_LEN write SHALL load bits[7:0]; the upper bits of writedata are ignored.
REQ-019 readdata SHALL be re-registered every clock from the address mux regardless of chipselect or read, with 1-cycle latency.
- Unused upper bits read 0.
- Addresses 3-7 read 0.
REQ-020 The strobe FSM SHALL have three states: IDLE, PULSE, GAP.
REQ-021 In IDLE, a TRIGGER write SHALL move the FSM to PULSE and load the counter with max(STROBE_LEN,1)-1.
REQ-022 out_strobe SHALL be 1 exactly while the FSM is in PULSE.
REQ-023 In PULSE, the counter SHALL decrement each cycle; at 0 the FSM SHALL go to GAP.
REQ-024 GAP SHALL last exactly one cycle, then return to IDLE.
REQ-025 The pulse width SHALL be exactly max(STROBE_LEN,1) cycles, so STROBE_LEN=0 behaves as 1.
REQ-026 STATUS.busy SHALL be 1 in PULSE and GAP, and 0 in IDLE.
REQ-027 A TRIGGER write in PULSE or GAP SHALL be ignored and SHALL set sticky STATUS.overrun.
REQ-028 Any write to STATUS SHALL clear overrun, whatever the writedata value.
REQ-029 A STROBE_LEN write during PULSE SHALL NOT change the current pulse; it applies to the next trigger.
REQ-030 DATA, OUTSET and OUTCLEAR writes SHALL be independent of the FSM and take effect while a strobe is active.

Reset
REQ-031 While reset_n=0, asynchronously:
- out_port = RESET_VALUE.
- STROBE_LEN = STROBE_LEN_RESET.
- FSM = IDLE, counter = 0, out_strobe = 0.
- overrun = 0, readdata = 0.
REQ-032 A reset asserted during PULSE SHALL drop out_strobe immediately and leave no residual pulse after release.
REQ-033 The first write SHALL be accepted on the first rising edge after reset_n deasserts.

Structure
REQ-034 A shared package cpu_write_diff_pio_pkg SHALL hold:
- the register address constants;
- the FSM state type (IDLE/PULSE/GAP);
- the STROBE_LEN width constant (8).
REQ-035 The FSM and counter SHALL be a sub-module cpu_write_diff_pio_strobe with:
- inputs trigger and len[7:0];
- outputs strobe, busy and overrun_set.
REQ-036 The top level SHALL hold the register file, the read mux and the overrun flag.

Verification
REQ-037 Reset, then read addresses 0,1,2 -> readdata 0x00, 0x04, 0x00 one cycle after each address; out_port=0x00, out_strobe=0.
REQ-038 Write DATA=0xA5, then OUTSET=0x0A, then OUTCLEAR=0x81 -> out_port 0xA5, then 0xAF, then 0x2E, each one cycle after its write.
REQ-039 STROBE_LEN=3, TRIGGER -> out_strobe high exactly 3 cycles, busy high 4 cycles, then IDLE; repeat with STROBE_LEN=0 -> strobe high exactly 1 cycle.
REQ-040 STROBE_LEN=5, TRIGGER, TRIGGER again 2 cycles later -> single 5-cycle pulse, STATUS reads 0x3; write STATUS -> reads 0x0 after the pulse.
REQ-041 STROBE_LEN=8, TRIGGER, assert reset_n=0 in cycle 3 of the pulse -> out_strobe 0 immediately, STATUS 0x0 after release; a new TRIGGER produces 4 cycles (reset length).
REQ-042 Write DATA with chipselect=0, and with write_n=1 -> out_port unchanged.
